// File: rtl/bcd_down_counter_mod10_pkg.sv
// Shared constants and digit type for the single-digit BCD down-counter.
package bcd_down_counter_mod10_pkg;

  localparam int unsigned BCD_WIDTH = 4;

  typedef logic [BCD_WIDTH-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

endpackage : bcd_down_counter_mod10_pkg

// File: rtl/bcd_down_counter_mod10.sv
// Mod-10 BCD down-counter digit with saturating synchronous load, count enable,
// asynchronous clear, and combinational borrow-out (tc) / zero flags for cascading.
module bcd_down_counter_mod10
  import bcd_down_counter_mod10_pkg::*;
(
  input  logic       clock,
  input  logic       clr,
  input  logic [3:0] data,
  input  logic       loadn,
  input  logic       enable,
  output bcd_digit_t ones,
  output logic       tc,
  output logic       zero
);

  bcd_digit_t next_ones;
  bcd_digit_t load_value;

  // Non-BCD load values clamp to 9 so the digit never leaves 0..9.
  always_comb begin
    load_value = bcd_digit_t'(data);
    if (bcd_digit_t'(data) > BCD_MAX) begin
      load_value = BCD_MAX;
    end
  end

  // Next-state select: load beats count, count beats hold.
  always_comb begin
    next_ones = ones;
    if (!loadn) begin
      next_ones = load_value;
    end else if (enable) begin
      if (ones == BCD_ZERO) begin
        next_ones = BCD_MAX;
      end else begin
        next_ones = ones - bcd_digit_t'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      ones <= BCD_ZERO;
    end else begin
      ones <= next_ones;
    end
  end

  // Combinational so the next digit decrements on the same edge this one wraps.
  assign zero = (ones == BCD_ZERO);
  assign tc   = enable & zero;

endmodule : bcd_down_counter_mod10

// File: tb/tb_bcd_down_counter_mod10.sv
// Directed self-checking bench for bcd_down_counter_mod10.
module tb_bcd_down_counter_mod10;

  logic       clock;
  logic       clr;
  logic [3:0] data;
  logic       loadn;
  logic       enable;
  logic [3:0] ones;
  logic       tc;
  logic       zero;

  int vectors;
  int miscompares;

  bcd_down_counter_mod10 dut (
    .clock  (clock),
    .clr    (clr),
    .data   (data),
    .loadn  (loadn),
    .enable (enable),
    .ones   (ones),
    .tc     (tc),
    .zero   (zero)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; data = 4'd0; loadn = 1'b1; enable = 1'b1;
    #3;
    vectors++;
    if (ones !== 4'd0 || zero !== 1'b1 || tc !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_en1: ones=%0d zero=%0b tc=%0b, want ones=0 zero=1 tc=1", ones, zero, tc);
    end
    enable = 1'b0;
    #1;
    vectors++;
    if (tc !== 1'b0 || zero !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_en0: tc=%0b zero=%0b, want tc=0 zero=1", tc, zero);
    end
    step();
    vectors++;
    if (ones !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_hold_edge: ones=%0d, want 0", ones);
    end
    clr = 1'b0;
    data = 4'd7; loadn = 1'b0;
    step();
    vectors++;
    if (ones !== 4'd7) begin
      miscompares++;
      $display("FAIL load7: ones=%0d, want 7", ones);
    end
    // Clear between edges must act immediately.
    #2 clr = 1'b1;
    #1;
    vectors++;
    if (ones !== 4'd0 || zero !== 1'b1) begin
      miscompares++;
      $display("FAIL async_clr: ones=%0d zero=%0b, want ones=0 zero=1", ones, zero);
    end
    #1 clr = 1'b0;
    loadn = 1'b1;
  endtask

  task automatic test_load_count();
    logic [3:0] exp;
    data = 4'd9; loadn = 1'b0; enable = 1'b0;
    step();
    loadn = 1'b1; enable = 1'b1;
    #1;
    vectors++;
    if (ones !== 4'd9 || tc !== 1'b0 || zero !== 1'b0) begin
      miscompares++;
      $display("FAIL count_start: ones=%0d tc=%0b zero=%0b, want 9/0/0", ones, tc, zero);
    end
    for (int i = 1; i <= 10; i++) begin
      step();
      exp = (i == 10) ? 4'd9 : 4'(9 - i);
      vectors++;
      if (ones !== exp || tc !== (exp == 4'd0) || zero !== (exp == 4'd0)) begin
        miscompares++;
        $display("FAIL count_seq[%0d]: ones=%0d tc=%0b zero=%0b, want ones=%0d tc=%0b zero=%0b",
                 i, ones, tc, zero, exp, (exp == 4'd0), (exp == 4'd0));
      end
    end
  endtask

  task automatic test_load_priority_hold();
    data = 4'd1; loadn = 1'b0; enable = 1'b1;
    step();
    vectors++;
    if (ones !== 4'd1) begin
      miscompares++;
      $display("FAIL load_over_count: ones=%0d, want 1", ones);
    end
    loadn = 1'b1; enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (ones !== 4'd1 || zero !== 1'b0 || tc !== 1'b0) begin
        miscompares++;
        $display("FAIL hold[%0d]: ones=%0d zero=%0b tc=%0b, want 1/0/0", i, ones, zero, tc);
      end
    end
  endtask

  task automatic test_saturate();
    data = 4'd12; loadn = 1'b0; enable = 1'b0;
    step();
    vectors++;
    if (ones !== 4'd9) begin
      miscompares++;
      $display("FAIL sat12: ones=%0d, want 9", ones);
    end
    data = 4'd3;
    step();
    data = 4'd15;
    step();
    vectors++;
    if (ones !== 4'd9) begin
      miscompares++;
      $display("FAIL sat15: ones=%0d, want 9", ones);
    end
    data = 4'd10;
    step();
    vectors++;
    if (ones !== 4'd9) begin
      miscompares++;
      $display("FAIL sat10: ones=%0d, want 9", ones);
    end
    data = 4'd0; enable = 1'b1;
    step();
    vectors++;
    if (ones !== 4'd0 || zero !== 1'b1 || tc !== 1'b1) begin
      miscompares++;
      $display("FAIL load0_en1: ones=%0d zero=%0b tc=%0b, want 0/1/1", ones, zero, tc);
    end
    loadn = 1'b1; enable = 1'b0;
  endtask

  task automatic test_clear_mid_count();
    data = 4'd9; loadn = 1'b0; enable = 1'b0;
    step();
    loadn = 1'b1; enable = 1'b1;
    repeat (4) step();
    vectors++;
    if (ones !== 4'd5) begin
      miscompares++;
      $display("FAIL pre_clr: ones=%0d, want 5", ones);
    end
    #1 clr = 1'b1;
    #1;
    vectors++;
    if (ones !== 4'd0 || zero !== 1'b1 || tc !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_clr: ones=%0d zero=%0b tc=%0b, want 0/1/1", ones, zero, tc);
    end
    #1 clr = 1'b0;
    step();
    vectors++;
    if (ones !== 4'd9) begin
      miscompares++;
      $display("FAIL post_clr: ones=%0d, want 9", ones);
    end
  endtask

  task automatic test_enable_gating();
    logic [7:0] pattern;
    logic [3:0] exp;
    pattern = 8'b1011_0010;
    data = 4'd0; loadn = 1'b0; enable = 1'b0;
    step();
    loadn = 1'b1;
    exp = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (exp != 4'd0) begin
        // Return to zero so tc gating is exercised each cycle.
        loadn = 1'b0; enable = 1'b0;
        step();
        loadn = 1'b1;
        exp = 4'd0;
      end
      enable = pattern[i];
      #1;
      vectors++;
      if (tc !== pattern[i] || zero !== 1'b1 || ones !== 4'd0) begin
        miscompares++;
        $display("FAIL gate[%0d]: tc=%0b zero=%0b ones=%0d, want tc=%0b zero=1 ones=0",
                 i, tc, zero, ones, pattern[i]);
      end
      step();
      exp = pattern[i] ? 4'd9 : 4'd0;
      vectors++;
      if (ones !== exp) begin
        miscompares++;
        $display("FAIL gate_edge[%0d]: ones=%0d, want %0d", i, ones, exp);
      end
    end
    enable = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    clr = 1'b1; data = 4'd0; loadn = 1'b1; enable = 1'b0;
    test_reset();
    test_load_count();
    test_load_priority_hold();
    test_saturate();
    test_clear_mid_count();
    test_enable_gating();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_bcd_down_counter_mod10

// File: doc/bcd_down_counter_mod10.md
Name: bcd_down_counter_mod10

Overview:
- Single-digit BCD down-counter, modulo 10, with synchronous parallel load, count enable and asynchronous clear.
- Building block for cascaded decimal timers and clocks (e.g. seconds and minutes digits).
- The tc output drives the enable of the next, more-significant digit; zero feeds terminal-condition logic.

Parameters:
- None. Width (4) and modulus (10) are fixed.

Ports:
- clock  in  1  rising-edge system clock
- clr  in  1  asynchronous active-high clear; forces count to 0
- data  in  4  parallel load value (BCD)
- loadn  in  1  synchronous load, active-low
- enable  in  1  count enable, active-high
- ones  out  4  current BCD digit, registered
- tc  out  1  terminal count / borrow-out to next digit, combinational
- zero  out  1  digit-is-zero flag, combinational

Behaviour:
- Interface: one clock (clock); reset (clr) is asynchronous and active-high.
- clr=1 sets ones=0 immediately, independent of clock, and holds it there while asserted.
  - Resulting outputs: zero=1, tc=enable.
  - Release of clr takes effect at the next rising clock edge.
- Priority at each rising clock edge, when clr=0: loadn=0 first, then enable=1, else hold.
- Load (loadn=0):
  - ones <= data when data<=9.
  - data in 10..15 loads 9 (saturate). ones never holds a non-BCD value.
  - Load ignores enable.
- Count (loadn=1, enable=1):
  - ones <= ones-1 when ones>0.
  - ones <= 9 when ones==0 (wrap, borrow).
- Hold (loadn=1, enable=0): ones unchanged.
- zero = (ones==0).
- tc = enable & (ones==0). Combinational, so a cascaded digit decrements on the same edge this digit wraps 0->9.
- Latency:
  - Load and count: 1 clock edge.
  - Clear: asynchronous, no clock needed.
  - tc/zero: combinational from ones and enable.
- Simultaneous events:
  - clr overrides everything.
  - Load overrides count.
  - Load of 0 with enable=1: ones=0 after the edge; tc follows enable combinationally.
- Count sequence with continuous enable: 9,8,7,...,1,0,9,...; period 10 clocks.
- tc asserts for exactly one clock per 10 when enable is held high.
- clr asserted mid-count: ones=0 immediately; counting resumes from 0 (next value 9) after release.

Decomposition:
- Shared package: constant BCD_MAX=4'd9, constant BCD_ZERO=4'd0, typedef bcd_digit_t (4-bit logic).
- Single module, no sub-modules: next-state mux, load saturation, and tc/zero decode are all in-line.
- Cascading into multi-digit counters is done by the parent (tc to the next enable); not part of this block.

Test Plan:
- Async clear: clr=1 between edges -> ones=0 at once, zero=1; with enable=1, tc=1 immediately.
- Load and count down: data=9, loadn=0 for 1 edge, then loadn=1, enable=1 -> ones 9,8,...,0,9 on successive edges; tc=1 only while ones=0; wrap to 9 after 10 edges.
- Load priority and hold: loadn=0, enable=1, data=1 -> ones=1 after the edge. Then loadn=1, enable=0 for 5 edges -> ones stays 1, zero=0, tc=0.
- Saturating load: data=4'd12, loadn=0 -> ones=9 after the edge; data=0 -> ones=0, zero=1.
- Clear mid-count: count from 9 to 5, then pulse clr=1 for half a cycle -> ones=0 asynchronously; next enabled edge -> ones=9.
- Enable gating of tc: ones=0 with enable toggling 0/1 -> tc mirrors enable and zero stays 1; ones changes only on edges where enable=1.
